pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter: LOAD_LAT, default 1; load-use stall length in cycles; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 idex_MemRead  input  1  MemRead held in the ID/EX register (the instruction now in EX is a load).
REQ-005 idex_writeReg  input  5  destination register held in ID/EX.
REQ-006 ifid_readReg1  input  5  first source register of the instruction in ID.
REQ-007 ifid_readReg2  input  5  second source register after the Reg2Loc mux.
REQ-008 ifid_usesReg2  input  1  ID instruction reads readReg2.
REQ-009 exmem_BranchTaken  input  1  branch resolved taken in MEM (Branch AND zero).
REQ-010 cnt_clr  input  1  synchronous clear of the performance counters.
REQ-011 pc_write  output  1  PC load enable.
REQ-012 ifid_write  output  1  IF/ID load enable.
REQ-013 idex_bubble  output  1  ID/EX loads all-zero control fields this cycle.
REQ-014 ifid_flush  output  1  IF/ID loads a NOP.
REQ-015 idex_flush  output  1  ID/EX loads a NOP.
REQ-016 exmem_flush  output  1  EX/MEM control fields are cleared.
REQ-017 hz_state  output  2  FSM state (RUN=00, STALL=01).
REQ-018 stall_cycles  output  16  count of stalled cycles.
REQ-019 flush_events  output  16  count of taken-branch flushes.

Function
REQ-020 hazard = idex_MemRead AND idex_writeReg != 31 AND (idex_writeReg == ifid_readReg1 OR (ifid_usesReg2 AND idex_writeReg == ifid_readReg2)); register 31 (XZR) never causes a hazard.
REQ-021 Control outputs shall be combinational functions of the state, rem_cnt and the inputs; all counters and state shall be registered.
REQ-022 Default output values: pc_write=1, ifid_write=1; all flush and bubble outputs 0.
REQ-023 If exmem_BranchTaken=1 in any state, the block shall drive ifid_flush=idex_flush=exmem_flush=1 and pc_write=1 (the PC loads the target).
REQ-024 When exmem_BranchTaken=1, ifid_write=1 and idex_bubble=0; the next state shall be RUN and rem_cnt shall be 0, which aborts any stall in progress.
REQ-025 In RUN, if hazard=1 and exmem_BranchTaken=0, the block shall drive pc_write=0, ifid_write=0 and idex_bubble=1 in that same cycle.
REQ-026 On the RUN hazard cycle with LOAD_LAT=1, the next state shall be RUN; with LOAD_LAT>1, the next state shall be STALL with rem_cnt=LOAD_LAT-1.
REQ-027 In STALL without a branch, the block shall drive pc_write=0, ifid_write=0 and idex_bubble=1, and shall decrement rem_cnt each cycle.
REQ-028 In STALL, when rem_cnt==1 the next state shall be RUN; the hazard input is ignored while in STALL.
REQ-029 Total stall length for one load-use event shall be exactly LOAD_LAT cycles.
REQ-030 stall_cycles shall increment by 1 on each cycle with pc_write=0.
REQ-031 flush_events shall increment by 1 on each cycle with exmem_BranchTaken=1.
REQ-032 Both counters shall saturate at 16'hFFFF and shall not wrap.
REQ-033 cnt_clr=1 shall zero both counters on the next edge, taking priority over any increment in that cycle.
REQ-034 If hazard and exmem_BranchTaken are both 1 in the same cycle, the flush shall win: no stall, no stall count, flush_events increments.

Reset
REQ-035 While rst_n=0: hz_state=RUN, rem_cnt=0, stall_cycles=0 and flush_events=0 immediately, without waiting for a clock edge.
REQ-036 While rst_n=0, control outputs shall be pc_write=1, ifid_write=1 and all flushes and bubble 0, regardless of the other inputs.
REQ-037 Reset asserted mid-stall shall abort the stall; after rst_n deasserts, the first edge shall evaluate from RUN.

Verification
REQ-038 LOAD_LAT=1; idex_MemRead=1, idex_writeReg=5, ifid_readReg1=5 for one cycle, then a bubble -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1; stall_cycles=1; state stays RUN.
REQ-039 LOAD_LAT=3, same hazard -> pc_write=0 for exactly 3 cycles; hz_state 00,01,01,00; stall_cycles=3.
REQ-040 idex_writeReg=31, ifid_readReg1=31, idex_MemRead=1 -> no stall; ifid_usesReg2=0 with a readReg2 match -> no stall.
REQ-041 LOAD_LAT=4; exmem_BranchTaken=1 in the 2nd stall cycle -> all three flushes=1 and pc_write=1 that cycle, then RUN; stall_cycles=1, flush_events=1.
REQ-042 Hazard and branch in the same cycle -> flushes asserted, idex_bubble=0, stall_cycles unchanged.
REQ-043 Preload the counters to 16'hFFFE and apply 3 branch cycles -> flush_events=FFFF; then cnt_clr=1 together with a branch -> flush_events=0; rst_n low mid-stall -> hz_state=00 immediately.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use stall and taken-branch flush control with saturating perf counters
module pipeline_hazard_ctrl #(
    parameter int LOAD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        idex_MemRead,
    input  logic [4:0]  idex_writeReg,
    input  logic [4:0]  ifid_readReg1,
    input  logic [4:0]  ifid_readReg2,
    input  logic        ifid_usesReg2,
    input  logic        exmem_BranchTaken,
    input  logic        cnt_clr,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_bubble,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic [1:0]  hz_state,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01
    } hz_state_t;

    localparam logic [3:0]  LAT_M1  = 4'(LOAD_LAT - 1);
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    hz_state_t  state_q, state_d;
    logic [3:0] rem_q, rem_d;
    logic       hazard;

    // XZR (r31) is hardwired zero, so a load targeting it can never create a dependency
    assign hazard = idex_MemRead && (idex_writeReg != 5'd31) &&
                    ((idex_writeReg == ifid_readReg1) ||
                     (ifid_usesReg2 && (idex_writeReg == ifid_readReg2)));

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (!rst_n) begin
            state_d = RUN;
            rem_d   = 4'd0;
        end else if (exmem_BranchTaken) begin
            // A taken branch squashes the younger instructions, including any stalled one
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = RUN;
            rem_d       = 4'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hazard) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = STALL;
                            rem_d   = LAT_M1;
                        end
                    end
                end
                STALL: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    rem_d       = rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    rem_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            rem_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= 16'd0;
            flush_events <= 16'd0;
        end else if (cnt_clr) begin
            stall_cycles <= 16'd0;
            flush_events <= 16'd0;
        end else begin
            if (!pc_write && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (exmem_BranchTaken && (flush_events != CNT_MAX)) begin
                flush_events <= flush_events + 16'd1;
            end
        end
    end

    assign hz_state = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - bench for pipeline_hazard_ctrl at LOAD_LAT 1, 3 and 4
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mr;
    logic [4:0] wr, r1, r2;
    logic       u2, br, clr;

    logic        pc_w[3], ifw_w[3], bub_w[3], iff_w[3], idf_w[3], emf_w[3];
    logic [1:0]  st_w[3];
    logic [15:0] sc_w[3], fe_w[3];

    int n_vec = 0;
    int n_fail = 0;

    int lat[3] = '{1, 3, 4};
    int m_left[3];
    int m_stall[3];
    int m_flush[3];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.LOAD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .idex_MemRead(mr), .idex_writeReg(wr),
        .ifid_readReg1(r1), .ifid_readReg2(r2), .ifid_usesReg2(u2),
        .exmem_BranchTaken(br), .cnt_clr(clr),
        .pc_write(pc_w[0]), .ifid_write(ifw_w[0]), .idex_bubble(bub_w[0]),
        .ifid_flush(iff_w[0]), .idex_flush(idf_w[0]), .exmem_flush(emf_w[0]),
        .hz_state(st_w[0]), .stall_cycles(sc_w[0]), .flush_events(fe_w[0]));

    pipeline_hazard_ctrl #(.LOAD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .idex_MemRead(mr), .idex_writeReg(wr),
        .ifid_readReg1(r1), .ifid_readReg2(r2), .ifid_usesReg2(u2),
        .exmem_BranchTaken(br), .cnt_clr(clr),
        .pc_write(pc_w[1]), .ifid_write(ifw_w[1]), .idex_bubble(bub_w[1]),
        .ifid_flush(iff_w[1]), .idex_flush(idf_w[1]), .exmem_flush(emf_w[1]),
        .hz_state(st_w[1]), .stall_cycles(sc_w[1]), .flush_events(fe_w[1]));

    pipeline_hazard_ctrl #(.LOAD_LAT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .idex_MemRead(mr), .idex_writeReg(wr),
        .ifid_readReg1(r1), .ifid_readReg2(r2), .ifid_usesReg2(u2),
        .exmem_BranchTaken(br), .cnt_clr(clr),
        .pc_write(pc_w[2]), .ifid_write(ifw_w[2]), .idex_bubble(bub_w[2]),
        .ifid_flush(iff_w[2]), .idex_flush(idf_w[2]), .exmem_flush(emf_w[2]),
        .hz_state(st_w[2]), .stall_cycles(sc_w[2]), .flush_events(fe_w[2]));

    typedef struct {
        logic       mr;
        logic [4:0] wr, r1, r2;
        logic       u2, br;
        logic       pc, ifw, bub, fl;
    } vec_t;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic hazard_f();
        return mr && (wr != 5'd31) && ((wr == r1) || (u2 && (wr == r2)));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_left[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
        end
    endtask

    // Reference: m_left is the number of forced stall cycles still owed after this one
    task automatic compare_all();
        logic busy, e_pc, e_bub, e_fl;
        if (!rst_n) model_reset();
        for (int k = 0; k < 3; k++) begin
            busy = (m_left[k] > 0);
            e_pc = 1'b1; e_bub = 1'b0; e_fl = 1'b0;
            if (rst_n) begin
                if (br) e_fl = 1'b1;
                else if (busy || hazard_f()) begin e_pc = 1'b0; e_bub = 1'b1; end
            end
            chk($sformatf("pc_write[%0d]", k),    16'(pc_w[k]),  16'(e_pc));
            chk($sformatf("ifid_write[%0d]", k),  16'(ifw_w[k]), 16'(e_pc));
            chk($sformatf("idex_bubble[%0d]", k), 16'(bub_w[k]), 16'(e_bub));
            chk($sformatf("ifid_flush[%0d]", k),  16'(iff_w[k]), 16'(e_fl));
            chk($sformatf("idex_flush[%0d]", k),  16'(idf_w[k]), 16'(e_fl));
            chk($sformatf("exmem_flush[%0d]", k), 16'(emf_w[k]), 16'(e_fl));
            chk($sformatf("hz_state[%0d]", k),    16'(st_w[k]),  busy ? 16'd1 : 16'd0);
            chk($sformatf("stall_cycles[%0d]", k), sc_w[k], 16'(m_stall[k]));
            chk($sformatf("flush_events[%0d]", k), fe_w[k], 16'(m_flush[k]));
        end
    endtask

    task automatic model_tick();
        logic busy, stalled;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            busy    = (m_left[k] > 0);
            stalled = !br && (busy || hazard_f());
            if (br)        m_left[k] = 0;
            else if (busy) m_left[k] = m_left[k] - 1;
            else if (stalled) m_left[k] = lat[k] - 1;
            if (clr) begin
                m_stall[k] = 0; m_flush[k] = 0;
            end else begin
                if (stalled && m_stall[k] < 65535) m_stall[k]++;
                if (br && m_flush[k] < 65535) m_flush[k]++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic step();
        #1;
        compare_all();
        tick();
    endtask

    task automatic idle();
        mr = 1'b0; wr = 5'd0; r1 = 5'd0; r2 = 5'd0; u2 = 1'b0; br = 1'b0; clr = 1'b0;
    endtask

    task automatic load_use();
        mr = 1'b1; wr = 5'd5; r1 = 5'd5; r2 = 5'd0; u2 = 1'b0;
    endtask

    function automatic logic [4:0] pick_reg();
        return ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
    endfunction

    vec_t vt[8];

    initial begin
        vt[0] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[1] = '{1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[2] = '{1'b1, 5'd7,  5'd1,  5'd7,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[3] = '{1'b1, 5'd7,  5'd1,  5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[4] = '{1'b0, 5'd5,  5'd5,  5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[5] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[6] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[7] = '{1'b1, 5'd0,  5'd0,  5'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0;
        idle();
        load_use();
        #3;
        compare_all();
        chk("reset_pc_write", 16'(pc_w[2]), 16'd1);
        tick();
        tick();
        rst_n = 1'b1;
        idle();
        step();

        // Table vectors, each from a quiet RUN state
        foreach (vt[i]) begin
            mr = vt[i].mr; wr = vt[i].wr; r1 = vt[i].r1; r2 = vt[i].r2;
            u2 = vt[i].u2; br = vt[i].br;
            #1;
            chk($sformatf("vec%0d_pc", i),  16'(pc_w[0]),  16'(vt[i].pc));
            chk($sformatf("vec%0d_ifw", i), 16'(ifw_w[0]), 16'(vt[i].ifw));
            chk($sformatf("vec%0d_bub", i), 16'(bub_w[0]), 16'(vt[i].bub));
            chk($sformatf("vec%0d_fl", i),  16'(emf_w[0]), 16'(vt[i].fl));
            step();
            idle();
            for (int j = 0; j < 4; j++) step();
        end

        // Three-cycle stall on LOAD_LAT=3, one on LOAD_LAT=1
        clr = 1'b1; step(); idle();
        load_use();
        #1;
        chk("lat3_st0", 16'(st_w[1]), 16'd0);
        chk("lat3_pc0", 16'(pc_w[1]), 16'd0);
        step();
        idle();
        #1;
        chk("lat3_st1", 16'(st_w[1]), 16'd1);
        chk("lat3_pc1", 16'(pc_w[1]), 16'd0);
        chk("lat1_st1", 16'(st_w[0]), 16'd0);
        chk("lat1_pc1", 16'(pc_w[0]), 16'd1);
        step();
        #1;
        chk("lat3_st2", 16'(st_w[1]), 16'd1);
        chk("lat3_pc2", 16'(pc_w[1]), 16'd0);
        step();
        #1;
        chk("lat3_st3", 16'(st_w[1]), 16'd0);
        chk("lat3_pc3", 16'(pc_w[1]), 16'd1);
        chk("lat3_stall_cnt", sc_w[1], 16'd3);
        chk("lat1_stall_cnt", sc_w[0], 16'd1);
        for (int j = 0; j < 3; j++) step();

        // Branch in the second stall cycle of LOAD_LAT=4 aborts the stall
        clr = 1'b1; step(); idle();
        load_use();
        step();
        idle(); br = 1'b1;
        #1;
        chk("lat4_br_fl", 16'(emf_w[2]), 16'd1);
        chk("lat4_br_iff", 16'(iff_w[2]), 16'd1);
        chk("lat4_br_pc", 16'(pc_w[2]), 16'd1);
        step();
        idle();
        #1;
        chk("lat4_br_st", 16'(st_w[2]), 16'd0);
        chk("lat4_br_stall", sc_w[2], 16'd1);
        chk("lat4_br_flush", fe_w[2], 16'd1);
        step();

        // Hazard and branch together: flush wins
        clr = 1'b1; step(); idle();
        load_use(); br = 1'b1;
        #1;
        chk("both_bub", 16'(bub_w[0]), 16'd0);
        chk("both_fl", 16'(idf_w[0]), 16'd1);
        step();
        idle();
        #1;
        chk("both_stall", sc_w[0], 16'd0);
        chk("both_flush", fe_w[0], 16'd1);
        step();

        // Drive flush_events up to saturation
        clr = 1'b1; step(); idle();
        br = 1'b1;
        for (int j = 0; j < 65534; j++) tick();
        #1;
        chk("sat_fe_fffe", fe_w[0], 16'hFFFE);
        for (int j = 0; j < 3; j++) step();
        #1;
        chk("sat_fe_ffff", fe_w[0], 16'hFFFF);
        chk("sat_fe_ffff_l4", fe_w[2], 16'hFFFF);
        clr = 1'b1;
        step();
        idle();
        #1;
        chk("clr_over_branch", fe_w[0], 16'd0);
        step();

        // Asynchronous reset in the middle of a stall
        load_use();
        step();
        idle();
        #1;
        chk("pre_rst_st", 16'(st_w[2]), 16'd1);
        load_use();
        rst_n = 1'b0;
        #1;
        chk("async_rst_st", 16'(st_w[2]), 16'd0);
        chk("async_rst_pc", 16'(pc_w[2]), 16'd1);
        chk("async_rst_bub", 16'(bub_w[0]), 16'd0);
        step();
        rst_n = 1'b1;
        idle();
        step();

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            mr    = ($urandom_range(0, 2) != 0);
            wr    = pick_reg();
            r1    = pick_reg();
            r2    = pick_reg();
            u2    = $urandom_range(0, 1) == 1;
            br    = ($urandom_range(0, 7) == 0);
            clr   = ($urandom_range(0, 31) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1;
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
